reg_file_mp: RTL
================

// Module: reg_file_mp
// PURPOSE
// - Parametrised successor register file: WIDTH x DEPTH storage, two async read ports, one sync write port.
// - Adds a runtime bulk-clear engine, an optional hardwired zero entry, and drop reporting for rejected writes.
// - Sits in the datapath as the general-purpose register bank feeding ALU operands.
// PARAMETERS
// - WIDTH     8    data bits per entry
// - DEPTH     256  number of entries, >=2, need not be a power of two
// - AW        $clog2(DEPTH)  address width (derived, do not override)
// - ZERO_REG0 0    1: entry 0 always reads 0 and ignores writes
// PORTS
// - clock      in   1      single clock, all state updates on rising edge
// - reset_n    in   1      asynchronous, active-low reset
// - rd_addr_a  in   AW     read port A address
// - rd_addr_b  in   AW     read port B address
// - rd_data_a  out  WIDTH  read port A data (combinational)
// - rd_data_b  out  WIDTH  read port B data (combinational)
// - wr_en      in   1      write strobe, sampled on rising clock
// - wr_addr    in   AW     write address
// - wr_data    in   WIDTH  write data
// - clear_req  in   1      start bulk clear, sampled on rising clock
// - clear_busy out  1      high while the clear engine runs
// - wr_drop    out  1      registered 1-cycle pulse: the write sampled last edge was rejected
// BEHAVIOUR
// - Reset (reset_n=0, async): all entries = 0; FSM = IDLE; clear counter = 0; clear_busy = 0; wr_drop = 0.
// - Read: rd_data_x = mem[rd_addr_x], combinational, no latency.
// - Read of out-of-range address (>= DEPTH) returns 0.
// - Read of address 0 with ZERO_REG0=1 returns 0.
// - Write: wr_en=1 at a rising edge updates mem[wr_addr]; visible on reads from the following cycle.
// - Write is dropped (no storage change, wr_drop=1 the next cycle) when any of these holds:
//   - wr_addr >= DEPTH;
//   - wr_addr = 0 with ZERO_REG0=1;
//   - the FSM is in CLEAR at that edge.
// - FSM states: IDLE and CLEAR.
//   - IDLE -> CLEAR: clear_req=1 at an edge; counter <= 0; clear_busy=1 from the next cycle.
//   - CLEAR: each edge writes mem[counter] <= 0 and increments counter.
//   - CLEAR -> IDLE: at the edge where counter = DEPTH-1; total DEPTH cycles busy.
// - Boundary conditions:
//   - clear_req while in CLEAR is ignored; it does not restart the counter.
//   - clear_req and wr_en at the same IDLE edge: the write commits, then clearing starts.
//   - Reads during CLEAR return live contents, so entries not yet cleared keep their old values.
//   - reset_n low mid-clear: immediate IDLE, all entries 0.
// - Widths: AW-bit addresses are zero-extended for range compare; counter is AW bits and never wraps past DEPTH-1.
// CONFIGURATION
// - Macro REG_FILE_BYPASS_EN.
// - Defined:
//   - If wr_en=1, the write is accepted, and rd_addr_x == wr_addr, then rd_data_x = wr_data in that same cycle.
//   - Dropped writes are never bypassed.
// - Undefined: no forwarding; the read returns the old contents until the next cycle.
// TESTING (WIDTH=8, DEPTH=16 unless noted)
// - Reset, then write 8'h55 to addr 10 and 8'hAA to addr 3 -> next cycle rd_data_a=8'h55 (addr 10), rd_data_b=8'hAA (addr 3).
// - Without REG_FILE_BYPASS_EN: write 8'h0F to addr 5 while rd_addr_a=5 -> old value during the write cycle, 8'h0F the next cycle.
// - With REG_FILE_BYPASS_EN: same stimulus -> rd_data_a=8'h0F in the write cycle itself.
// - ZERO_REG0=1: write 8'hFF to addr 0 -> rd_data_a=0 and wr_drop=1 for one cycle.
// - DEPTH=12: write to addr 13 -> wr_drop=1 and no entry changes; read of addr 13 returns 0.
// - Fill all entries with 8'hC3, then pulse clear_req:
//   - clear_busy is high for exactly 16 cycles;
//   - a write issued mid-clear gets wr_drop=1;
//   - all reads return 0 afterwards.
// - Assert reset_n low 4 cycles into a clear -> clear_busy=0 immediately and all entries read 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Register file: two async read ports, one write port, bulk-clear engine.
// Optional same-cycle write-to-read forwarding under REG_FILE_BYPASS_EN.
module reg_file_mp #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 256,
  parameter int AW        = $clog2(DEPTH),
  parameter bit ZERO_REG0 = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic             wr_drop
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [0:0]       state;
  logic [AW-1:0]    cnt;
  logic             wr_ok;

  // Address maps to real, writable storage.
  function automatic logic live(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG0 && a == '0);
  endfunction

  assign wr_ok      = wr_en && live(wr_addr) && (state == IDLE);
  assign clear_busy = (state == CLEAR);

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (live(rd_addr_a)) rd_data_a = mem[rd_addr_a];
    if (live(rd_addr_b)) rd_data_b = mem[rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && rd_addr_a == wr_addr) rd_data_a = wr_data;
    if (wr_ok && rd_addr_b == wr_addr) rd_data_b = wr_data;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state   <= IDLE;
      cnt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && !wr_ok;
      if (wr_ok) mem[wr_addr] <= wr_data;
      unique case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          if (cnt == AW'(DEPTH - 1)) state <= IDLE;
          else cnt <= cnt + AW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
